// File: rtl/operand_fetch_stage_if.sv
// Bundle between ID-side producers and the operand fetch stage.
// slave: the stage itself; master: upstream/driver side.
interface operand_fetch_stage_if #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic          id_valid;
   logic [AW-1:0] id_ra;
   logic [AW-1:0] id_rb;
   logic [AW-1:0] id_rd;
   logic          id_rd_en;
   logic          id_is_load;
   logic [AW-1:0] rf_ra;
   logic [AW-1:0] rf_rb;
   logic [DW-1:0] rf_pa;
   logic [DW-1:0] rf_pb;
   logic [DW-1:0] ex_result;
   logic [AW-1:0] mem_rd;
   logic          mem_rd_en;
   logic [DW-1:0] mem_result;
   logic [AW-1:0] wb_rd;
   logic          wb_rd_en;
   logic [DW-1:0] wb_result;
   logic          flush;
   logic          hold;
   logic          stall;
   logic          ex_valid;
   logic [DW-1:0] ex_opa;
   logic [DW-1:0] ex_opb;
   logic [AW-1:0] ex_rd;
   logic          ex_rd_en;
   logic          ex_is_load;
   logic [CNT_W-1:0] stall_cnt;

   modport slave (
      input  id_valid, id_ra, id_rb, id_rd, id_rd_en, id_is_load,
      input  rf_pa, rf_pb, ex_result,
      input  mem_rd, mem_rd_en, mem_result,
      input  wb_rd, wb_rd_en, wb_result,
      input  flush, hold,
      output rf_ra, rf_rb, stall,
      output ex_valid, ex_opa, ex_opb, ex_rd, ex_rd_en, ex_is_load,
      output stall_cnt
   );

   modport master (
      output id_valid, id_ra, id_rb, id_rd, id_rd_en, id_is_load,
      output rf_pa, rf_pb, ex_result,
      output mem_rd, mem_rd_en, mem_result,
      output wb_rd, wb_rd_en, wb_result,
      output flush, hold,
      input  rf_ra, rf_rb, stall,
      input  ex_valid, ex_opa, ex_opb, ex_rd, ex_rd_en, ex_is_load,
      input  stall_cnt
   );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: RF read select, EX/MEM/WB forwarding, GR0 = 0,
// load-use bubble, ID/EX register with hold/flush, bubble counter.
module operand_fetch_stage #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst_n,
   operand_fetch_stage_if.slave bus
);
   logic             ex_valid;
   logic [DW-1:0]    ex_opa;
   logic [DW-1:0]    ex_opb;
   logic [AW-1:0]    ex_rd;
   logic             ex_rd_en;
   logic             ex_is_load;
   logic [CNT_W-1:0] stall_cnt;
   logic [DW-1:0]    opa;
   logic [DW-1:0]    opb;
   logic             fwd_ex;
   logic             lu;

   assign bus.rf_ra = bus.id_ra;
   assign bus.rf_rb = bus.id_rb;

   // A load in EX has no data yet; it is covered by the bubble.
   assign fwd_ex = ex_valid & ex_rd_en & ~ex_is_load;

   always_comb begin
      if (bus.id_ra == '0)
         opa = '0;
      else if (fwd_ex && ex_rd == bus.id_ra)
         opa = bus.ex_result;
      else if (bus.mem_rd_en && bus.mem_rd == bus.id_ra)
         opa = bus.mem_result;
      else if (bus.wb_rd_en && bus.wb_rd == bus.id_ra)
         opa = bus.wb_result;
      else
         opa = bus.rf_pa;
   end

   always_comb begin
      if (bus.id_rb == '0)
         opb = '0;
      else if (fwd_ex && ex_rd == bus.id_rb)
         opb = bus.ex_result;
      else if (bus.mem_rd_en && bus.mem_rd == bus.id_rb)
         opb = bus.mem_result;
      else if (bus.wb_rd_en && bus.wb_rd == bus.id_rb)
         opb = bus.wb_result;
      else
         opb = bus.rf_pb;
   end

   assign lu = bus.id_valid & ex_valid & ex_is_load
             & (ex_rd != '0)
             & ((ex_rd == bus.id_ra) | (ex_rd == bus.id_rb));

   assign bus.stall = bus.hold | (lu & ~bus.flush);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_opa     <= '0;
         ex_opb     <= '0;
         ex_rd      <= '0;
         ex_rd_en   <= 1'b0;
         ex_is_load <= 1'b0;
         stall_cnt  <= '0;
      end else if (bus.hold) begin
         // freeze; a pending flush must be re-presented
      end else if (bus.flush) begin
         ex_valid   <= 1'b0;
         ex_rd_en   <= 1'b0;
         ex_is_load <= 1'b0;
      end else if (lu) begin
         ex_valid   <= 1'b0;
         ex_rd_en   <= 1'b0;
         ex_is_load <= 1'b0;
         if (stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
         ex_valid   <= bus.id_valid;
         ex_opa     <= opa;
         ex_opb     <= opb;
         ex_rd      <= bus.id_rd;
         ex_rd_en   <= bus.id_rd_en & bus.id_valid;
         ex_is_load <= bus.id_is_load & bus.id_valid;
      end
   end

   assign bus.ex_valid   = ex_valid;
   assign bus.ex_opa     = ex_opa;
   assign bus.ex_opb     = ex_opb;
   assign bus.ex_rd      = ex_rd;
   assign bus.ex_rd_en   = ex_rd_en;
   assign bus.ex_is_load = ex_is_load;
   assign bus.stall_cnt  = stall_cnt;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: forwarding table plus
// sequences for reset, load-use, flush/hold overlap, saturation.
module tb_operand_fetch_stage;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int CNT_W = 2;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   operand_fetch_stage_if #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) bus ();

   operand_fetch_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      logic [AW-1:0] rd;
      logic [AW-1:0] mem_rd;
      logic          mem_en;
      logic [DW-1:0] mem_res;
      logic [AW-1:0] wb_rd;
      logic          wb_en;
      logic [DW-1:0] wb_res;
      logic [DW-1:0] pa;
      logic [DW-1:0] pb;
      logic [DW-1:0] opa;
      logic [DW-1:0] opb;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid   = 1'b0;
      bus.id_ra      = '0;
      bus.id_rb      = '0;
      bus.id_rd      = '0;
      bus.id_rd_en   = 1'b0;
      bus.id_is_load = 1'b0;
      bus.rf_pa      = '0;
      bus.rf_pb      = '0;
      bus.ex_result  = '0;
      bus.mem_rd     = '0;
      bus.mem_rd_en  = 1'b0;
      bus.mem_result = '0;
      bus.wb_rd      = '0;
      bus.wb_rd_en   = 1'b0;
      bus.wb_result  = '0;
      bus.flush      = 1'b0;
      bus.hold       = 1'b0;
   endtask

   task automatic issue(input logic [AW-1:0] rd, input logic rd_en,
                        input logic is_load, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb);
      bus.id_valid   = 1'b1;
      bus.id_rd      = rd;
      bus.id_rd_en   = rd_en;
      bus.id_is_load = is_load;
      bus.id_ra      = ra;
      bus.id_rb      = rb;
   endtask

   initial begin
      tbl[0] = '{5'd3, 5'd4, 5'd1, 5'd3, 1'b1, 32'h22, 5'd3, 1'b1,
                 32'h33, 32'h44, 32'h55, 32'h22, 32'h55};
      tbl[1] = '{5'd3, 5'd4, 5'd1, 5'd3, 1'b0, 32'h22, 5'd3, 1'b1,
                 32'h33, 32'h44, 32'h55, 32'h33, 32'h55};
      tbl[2] = '{5'd3, 5'd4, 5'd1, 5'd3, 1'b0, 32'h22, 5'd3, 1'b0,
                 32'h33, 32'h44, 32'h55, 32'h44, 32'h55};
      tbl[3] = '{5'd0, 5'd0, 5'd2, 5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0,
                 1'b1, 32'hFFFF_FFFF, 32'h77, 32'h88, 32'h0, 32'h0};
      tbl[4] = '{5'd7, 5'd7, 5'd3, 5'd7, 1'b1, 32'h1234, 5'd7, 1'b1,
                 32'h5678, 32'h1, 32'h2, 32'h1234, 32'h1234};
      tbl[5] = '{5'd9, 5'd10, 5'd4, 5'd10, 1'b1, 32'hA, 5'd9, 1'b1,
                 32'hB, 32'h1, 32'h2, 32'hB, 32'hA};
      tbl[6] = '{5'd1, 5'd2, 5'd5, 5'd1, 1'b0, 32'hDEAD, 5'd2, 1'b0,
                 32'hBEEF, 32'h100, 32'h200, 32'h100, 32'h200};
      tbl[7] = '{5'd31, 5'd31, 5'd6, 5'd30, 1'b1, 32'hBEEF, 5'd31,
                 1'b1, 32'hCAFE, 32'h3, 32'h4, 32'hCAFE, 32'hCAFE};

      total = 0;
      bad   = 0;
      clk   = 1'b0;
      rst_n = 1'b0;
      idle();
      issue(5'd6, 1'b1, 1'b1, 5'd1, 5'd2);
      repeat (2) tick();
      chk("rst_valid", 32'(bus.ex_valid), 0);
      chk("rst_opa", bus.ex_opa, 0);
      chk("rst_opb", bus.ex_opb, 0);
      chk("rst_rd", 32'(bus.ex_rd), 0);
      chk("rst_rd_en", 32'(bus.ex_rd_en), 0);
      chk("rst_is_load", 32'(bus.ex_is_load), 0);
      chk("rst_cnt", 32'(bus.stall_cnt), 0);
      chk("rst_stall0", 32'(bus.stall), 0);
      bus.hold = 1'b1;
      #1 chk("rst_stall_hold", 32'(bus.stall), 1);
      bus.hold = 1'b0;

      issue(5'd6, 1'b1, 1'b0, 5'd0, 5'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_valid", 32'(bus.ex_valid), 1);
      chk("rel_rd", 32'(bus.ex_rd), 6);
      chk("rel_rd_en", 32'(bus.ex_rd_en), 1);

      // EX forwarding wins over MEM/WB/RF
      issue(5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
      tick();
      issue(5'd3, 1'b0, 1'b0, 5'd3, 5'd4);
      bus.ex_result  = 32'h11;
      bus.mem_rd     = 5'd3;
      bus.mem_rd_en  = 1'b1;
      bus.mem_result = 32'h22;
      bus.wb_rd      = 5'd3;
      bus.wb_rd_en   = 1'b1;
      bus.wb_result  = 32'h33;
      bus.rf_pa      = 32'h44;
      bus.rf_pb      = 32'h55;
      #1 chk("exfwd_stall", 32'(bus.stall), 0);
      tick();
      chk("exfwd_opa", bus.ex_opa, 32'h11);
      chk("exfwd_opb", bus.ex_opb, 32'h55);

      // table: EX holds no-write instructions
      for (int i = 0; i < 8; i++) begin
         issue(tbl[i].rd, 1'b0, 1'b0, tbl[i].ra, tbl[i].rb);
         bus.ex_result  = 32'hEEEE_EEEE;
         bus.mem_rd     = tbl[i].mem_rd;
         bus.mem_rd_en  = tbl[i].mem_en;
         bus.mem_result = tbl[i].mem_res;
         bus.wb_rd      = tbl[i].wb_rd;
         bus.wb_rd_en   = tbl[i].wb_en;
         bus.wb_result  = tbl[i].wb_res;
         bus.rf_pa      = tbl[i].pa;
         bus.rf_pb      = tbl[i].pb;
         #1;
         chk($sformatf("v%0d_rf_ra", i), 32'(bus.rf_ra), 32'(tbl[i].ra));
         chk($sformatf("v%0d_rf_rb", i), 32'(bus.rf_rb), 32'(tbl[i].rb));
         chk($sformatf("v%0d_stall", i), 32'(bus.stall), 0);
         tick();
         chk($sformatf("v%0d_valid", i), 32'(bus.ex_valid), 1);
         chk($sformatf("v%0d_opa", i), bus.ex_opa, tbl[i].opa);
         chk($sformatf("v%0d_opb", i), bus.ex_opb, tbl[i].opb);
         chk($sformatf("v%0d_rd", i), 32'(bus.ex_rd), 32'(tbl[i].rd));
         chk($sformatf("v%0d_rd_en", i), 32'(bus.ex_rd_en), 0);
      end

      // GR0 with EX writing r0
      idle();
      issue(5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
      tick();
      issue(5'd9, 1'b0, 1'b0, 5'd0, 5'd0);
      bus.ex_result  = 32'hFFFF_FFFF;
      bus.mem_rd_en  = 1'b1;
      bus.mem_result = 32'hFFFF_FFFF;
      bus.wb_rd_en   = 1'b1;
      bus.wb_result  = 32'hFFFF_FFFF;
      bus.rf_pa      = 32'h44;
      bus.rf_pb      = 32'h44;
      #1 chk("gr0_stall", 32'(bus.stall), 0);
      tick();
      chk("gr0_opa", bus.ex_opa, 0);
      chk("gr0_opb", bus.ex_opb, 0);
      // load to r0 never stalls
      issue(5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      tick();
      issue(5'd9, 1'b0, 1'b0, 5'd0, 5'd0);
      #1 chk("gr0_ld_stall", 32'(bus.stall), 0);
      tick();
      chk("gr0_ld_valid", 32'(bus.ex_valid), 1);
      chk("gr0_ld_cnt", 32'(bus.stall_cnt), 0);

      // load-use: one bubble then MEM forward
      idle();
      issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd0);
      tick();
      issue(5'd8, 1'b1, 1'b0, 5'd1, 5'd5);
      bus.rf_pa = 32'h100;
      bus.rf_pb = 32'h999;
      #1 chk("lu_stall", 32'(bus.stall), 1);
      tick();
      chk("lu_bub_valid", 32'(bus.ex_valid), 0);
      chk("lu_bub_rd_en", 32'(bus.ex_rd_en), 0);
      chk("lu_bub_is_load", 32'(bus.ex_is_load), 0);
      chk("lu_cnt", 32'(bus.stall_cnt), 1);
      chk("lu_stall_off", 32'(bus.stall), 0);
      bus.mem_rd     = 5'd5;
      bus.mem_rd_en  = 1'b1;
      bus.mem_result = 32'hABCD;
      tick();
      chk("lu_valid", 32'(bus.ex_valid), 1);
      chk("lu_opb", bus.ex_opb, 32'hABCD);
      chk("lu_opa", bus.ex_opa, 32'h100);
      chk("lu_rd", 32'(bus.ex_rd), 8);
      chk("lu_rd_en", 32'(bus.ex_rd_en), 1);

      // load-use with flush
      idle();
      issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd0);
      tick();
      issue(5'd8, 1'b1, 1'b0, 5'd0, 5'd5);
      bus.flush = 1'b1;
      #1 chk("fl_stall", 32'(bus.stall), 0);
      tick();
      chk("fl_valid", 32'(bus.ex_valid), 0);
      chk("fl_rd_en", 32'(bus.ex_rd_en), 0);
      chk("fl_cnt", 32'(bus.stall_cnt), 1);
      bus.flush = 1'b0;

      // load-use with hold (flush ignored while held)
      issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd0);
      tick();
      issue(5'd8, 1'b1, 1'b0, 5'd2, 5'd5);
      bus.rf_pa = 32'h300;
      bus.hold  = 1'b1;
      bus.flush = 1'b1;
      #1 chk("hd_stall", 32'(bus.stall), 1);
      tick();
      tick();
      chk("hd_valid", 32'(bus.ex_valid), 1);
      chk("hd_is_load", 32'(bus.ex_is_load), 1);
      chk("hd_rd", 32'(bus.ex_rd), 5);
      chk("hd_rd_en", 32'(bus.ex_rd_en), 1);
      chk("hd_opa", bus.ex_opa, 0);
      chk("hd_cnt", 32'(bus.stall_cnt), 1);
      bus.hold  = 1'b0;
      bus.flush = 1'b0;
      #1 chk("hd_rel_stall", 32'(bus.stall), 1);
      tick();
      chk("hd_rel_valid", 32'(bus.ex_valid), 0);
      chk("hd_rel_cnt", 32'(bus.stall_cnt), 2);

      // five back-to-back load-use hazards: counter pins at 3
      issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd5);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("sat%0d_stall", i), 32'(bus.stall), 32'(i % 2));
         tick();
         chk($sformatf("sat%0d_cnt", i), 32'(bus.stall_cnt),
             ((2 + (i + 1) / 2) > 3) ? 3 : 2 + (i + 1) / 2);
      end

      // reset during a stall
      tick();
      chk("mr_pre_stall", 32'(bus.stall), 1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid", 32'(bus.ex_valid), 0);
      chk("mr_cnt", 32'(bus.stall_cnt), 0);
      chk("mr_stall", 32'(bus.stall), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mr_acc_valid", 32'(bus.ex_valid), 1);
      chk("mr_acc_is_load", 32'(bus.ex_is_load), 1);
      chk("mr_acc_rd", 32'(bus.ex_rd), 5);
      chk("mr_acc_cnt", 32'(bus.stall_cnt), 0);
      chk("mr_acc_stall", 32'(bus.stall), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
